// File: rtl/cpu_fetch.sv
// cpu_fetch -- instruction fetch unit with an in-order prefetch buffer.
//
// Purpose:
//   Issues sequential word-aligned fetch requests to instruction memory and
//   buffers the returned words, each tagged with its address, in a small FIFO
//   for the decode stage. A redirect flushes the buffer and restarts fetch at a
//   new address. Responses to requests that were still outstanding at the
//   redirect are counted and silently discarded when they come back.
//
// Parameters:
//   ADDR_W      instruction address width (16..32)
//   FIFO_DEPTH  prefetch buffer entries (power of two, >= 2)
//   RESET_PC    first fetch address after reset (bits [1:0] zero)
//
// Ports:
//   clk, rst_n                     clock and synchronous active-low reset
//   redirect_valid, redirect_pc    flush and restart fetch at redirect_pc
//   imem_req_valid/ready/addr      fetch request handshake
//   imem_rsp_valid/data            in-order instruction responses
//   inst_valid/ready, inst, inst_pc  head of the prefetch buffer
//   perf_bubble_cnt                (only with CPU_FETCH_PERF_EN) cycles with no
//                                  instruction offered and no redirect
//
// Optional feature macro: CPU_FETCH_PERF_EN
module cpu_fetch #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef CPU_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  // Address of the next response that will be kept; requests between
  // redirects are sequential, so this simply follows the kept responses.
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;

  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

  logic              credit_ok;
  logic              req_fire;
  logic              rsp_drop;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_aligned;

  // Buffered plus outstanding words never exceed the buffer size, so every
  // response that is kept always finds a free slot.
  assign credit_ok        = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid   = rst_n && !redirect_valid && credit_ok;
  assign imem_req_addr    = fetch_pc_q;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign rsp_drop         = imem_rsp_valid && (drop_q != '0);
  assign push             = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign inst_valid       = (count_q != '0) && !redirect_valid;
  assign pop              = inst_valid && inst_ready;
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // Outputs read straight from registered storage; gated to zero when empty.
  assign inst    = (count_q != '0) ? data_mem[head_q] : 32'h0;
  assign inst_pc = (count_q != '0) ? pc_mem[head_q]   : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    drop_d     = drop_q;
    // Every response retires one outstanding request, kept or dropped.
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      // Everything still outstanding after this edge belongs to the old
      // stream, including words owed from earlier redirects.
      drop_d     = inflight_d;
    end else begin
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        tail_d   = tail_q + PW'(1);
        rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC[ADDR_W-1:0];
      rsp_pc_q   <= RESET_PC[ADDR_W-1:0];
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      data_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]   <= rsp_pc_q;
    end
  end

`ifdef CPU_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_bubble_cnt <= 32'h0;
    end else if (!inst_valid && !redirect_valid) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch -- directed bench for cpu_fetch. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well before the rising edge.
// A second instance with ADDR_W=16 covers address wrap-around.
module tb_cpu_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // 16-bit instance
  logic        rst16_n;
  logic        redirect16;
  logic [15:0] redirect_pc16;
  logic        req_valid16;
  logic [15:0] req_addr16;
  logic        req_ready16;
  logic        rsp_valid16;
  logic [31:0] rsp_data16;
  logic        inst_valid16;
  logic [31:0] inst16;
  logic [15:0] inst_pc16;
  logic        inst_ready16;

`ifdef CPU_FETCH_PERF_EN
  logic [31:0] perf_main;
  logic [31:0] perf16;
`endif

  cpu_fetch #(.ADDR_W(32), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef CPU_FETCH_PERF_EN
    ,
    .perf_bubble_cnt(perf_main)
`endif
  );

  cpu_fetch #(.ADDR_W(16), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut16 (
    .clk            (clk),
    .rst_n          (rst16_n),
    .redirect_valid (redirect16),
    .redirect_pc    (redirect_pc16),
    .imem_req_valid (req_valid16),
    .imem_req_addr  (req_addr16),
    .imem_req_ready (req_ready16),
    .imem_rsp_valid (rsp_valid16),
    .imem_rsp_data  (rsp_data16),
    .inst_valid     (inst_valid16),
    .inst           (inst16),
    .inst_pc        (inst_pc16),
    .inst_ready     (inst_ready16)
`ifdef CPU_FETCH_PERF_EN
    ,
    .perf_bubble_cnt(perf16)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mem_lat = 1;

  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pc_log[$];
  logic [31:0] inst_log[$];
  int          pc_cyc[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  logic        acc16;
  logic [15:0] prev_addr16;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 ^ a;
  endfunction

  // One clock cycle of the 32-bit memory and consumer models.
  task automatic step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      req_log.push_back(imem_req_addr);
      req_cyc.push_back(cyc);
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + mem_lat);
      $display("[TB] cyc %0d request addr=%h", cyc, imem_req_addr);
    end
    if (inst_valid && inst_ready) begin
      pc_log.push_back(inst_pc);
      inst_log.push_back(inst);
      pc_cyc.push_back(cyc);
      $display("[TB] cyc %0d inst pc=%h data=%h", cyc, inst_pc, inst);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    mem_lat        = 1;
    step();
    step();
    req_log.delete(); req_cyc.delete();
    pc_log.delete(); inst_log.delete(); pc_cyc.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", inst); end
    tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    rst_n = 1'b1;
    #1;
    tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL release_req_valid: got %b want 1", imem_req_valid); end
    tests++; if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL release_req_addr: got %h want 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    int c0;
    do_reset();
    c0 = cyc;
    repeat (10) step();
    tests++; if (req_log.size() < 6) begin fails++; $display("FAIL stream_req_count: got %0d want >=6", req_log.size()); end
    tests++; if (pc_log.size() < 6) begin fails++; $display("FAIL stream_inst_count: got %0d want >=6", pc_log.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (req_log[i] !== 32'(i*4)) begin fails++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, req_log[i], 32'(i*4)); end
      tests++; if (req_cyc[i] != c0 + i) begin fails++; $display("FAIL stream_req_cyc[%0d]: got %0d want %0d", i, req_cyc[i], c0 + i); end
      tests++; if (pc_log[i] !== 32'(i*4)) begin fails++; $display("FAIL stream_inst_pc[%0d]: got %h want %h", i, pc_log[i], 32'(i*4)); end
      tests++; if (pc_cyc[i] != c0 + 2 + i) begin fails++; $display("FAIL stream_inst_cyc[%0d]: got %0d want %0d", i, pc_cyc[i], c0 + 2 + i); end
      tests++; if (inst_log[i] !== mem_word(32'(i*4))) begin fails++; $display("FAIL stream_inst_data[%0d]: got %h want %h", i, inst_log[i], mem_word(32'(i*4))); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    repeat (10) step();
    tests++; if (req_log.size() != 4) begin fails++; $display("FAIL bp_req_count: got %0d want 4", req_log.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (req_log[i] !== 32'(i*4)) begin fails++; $display("FAIL bp_req_addr[%0d]: got %h want %h", i, req_log[i], 32'(i*4)); end
    end
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_valid_low: got %b want 0", imem_req_valid); end
    tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL bp_inst_valid: got %b want 1", inst_valid); end
    tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL bp_head_pc: got %h want 0", inst_pc); end
    inst_ready = 1'b1;
    repeat (8) step();
    tests++; if (pc_log.size() < 6) begin fails++; $display("FAIL bp_drain_count: got %0d want >=6", pc_log.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (pc_log[i] !== 32'(i*4)) begin fails++; $display("FAIL bp_order[%0d]: got %h want %h", i, pc_log[i], 32'(i*4)); end
      tests++; if (inst_log[i] !== mem_word(32'(i*4))) begin fails++; $display("FAIL bp_data[%0d]: got %h want %h", i, inst_log[i], mem_word(32'(i*4))); end
    end
  endtask

  task automatic test_redirect();
    int c0;
    do_reset();
    mem_lat = 3;
    c0 = cyc;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_req_withdrawn: got %b want 0", imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL redir_req_valid: got %b want 1", imem_req_valid); end
    tests++; if (imem_req_addr !== 32'h100) begin fails++; $display("FAIL redir_req_addr: got %h want 00000100", imem_req_addr); end
    repeat (10) step();
    tests++; if (pc_log.size() < 2) begin fails++; $display("FAIL redir_inst_count: got %0d want >=2", pc_log.size()); end
    tests++; if (pc_log[0] !== 32'h100) begin fails++; $display("FAIL redir_first_pc: got %h want 00000100", pc_log[0]); end
    tests++; if (inst_log[0] !== mem_word(32'h100)) begin fails++; $display("FAIL redir_first_data: got %h want %h", inst_log[0], mem_word(32'h100)); end
    tests++; if (pc_cyc[0] != c0 + 7) begin fails++; $display("FAIL redir_first_cyc: got %0d want %0d", pc_cyc[0], c0 + 7); end
    tests++; if (pc_log[1] !== 32'h104) begin fails++; $display("FAIL redir_second_pc: got %h want 00000104", pc_log[1]); end
    mem_lat = 1;
  endtask

  task automatic test_flush_full();
    do_reset();
    inst_ready = 1'b0;
    repeat (6) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    #1;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL flush_inst_valid_forced: got %b want 0", inst_valid); end
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #1;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL flush_cleared: got %b want 0", inst_valid); end
    tests++; if (imem_req_addr !== 32'h40) begin fails++; $display("FAIL flush_req_addr: got %h want 00000040", imem_req_addr); end
    repeat (6) step();
    tests++; if (pc_log[0] !== 32'h40) begin fails++; $display("FAIL flush_first_pc: got %h want 00000040", pc_log[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_lat = 3;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    #1;
    tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL b2b_req_valid: got %b want 1", imem_req_valid); end
    tests++; if (imem_req_addr !== 32'h300) begin fails++; $display("FAIL b2b_req_addr: got %h want 00000300", imem_req_addr); end
    repeat (10) step();
    tests++; if (pc_log.size() < 2) begin fails++; $display("FAIL b2b_inst_count: got %0d want >=2", pc_log.size()); end
    tests++; if (pc_log[0] !== 32'h300) begin fails++; $display("FAIL b2b_first_pc: got %h want 00000300", pc_log[0]); end
    tests++; if (inst_log[0] !== mem_word(32'h300)) begin fails++; $display("FAIL b2b_first_data: got %h want %h", inst_log[0], mem_word(32'h300)); end
    tests++; if (pc_log[1] !== 32'h304) begin fails++; $display("FAIL b2b_second_pc: got %h want 00000304", pc_log[1]); end
    tests++; if (inst_log[1] !== mem_word(32'h304)) begin fails++; $display("FAIL b2b_second_data: got %h want %h", inst_log[1], mem_word(32'h304)); end
    mem_lat = 1;
  endtask

  task automatic test_stall_and_reset();
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b want 1", i, imem_req_valid); end
      tests++; if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL stall_addr[%0d]: got %h want 0", i, imem_req_addr); end
      step();
    end
    imem_req_ready = 1'b1;
    repeat (4) step();
    tests++; if (req_log.size() != 4) begin fails++; $display("FAIL stall_resume_count: got %0d want 4", req_log.size()); end
    tests++; if (req_log[3] !== 32'hC) begin fails++; $display("FAIL stall_resume_addr: got %h want 0000000c", req_log[3]); end
    rst_n = 1'b0;
    step();
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL midrst_inst_valid: got %b want 0", inst_valid); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL midrst_inst: got %h want 0", inst); end
    tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL midrst_inst_pc: got %h want 0", inst_pc); end
    step();
    rst_n = 1'b1;
    #1;
    tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL midrst_restart_valid: got %b want 1", imem_req_valid); end
    tests++; if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL midrst_restart_addr: got %h want 0", imem_req_addr); end
  endtask

  // 16-bit instance: drive one cycle of its 1-cycle memory, then settle.
  task automatic wrap_drive(input logic redir);
    redirect16    = redir;
    redirect_pc16 = 16'hFFFE;
    rsp_valid16   = acc16;
    rsp_data16    = 32'hB000_0000 | {16'h0, prev_addr16};
    #1;
  endtask

  task automatic wrap_advance();
    acc16       = req_valid16 && req_ready16;
    prev_addr16 = req_addr16;
    if (acc16) $display("[TB] wrap request addr=%h", req_addr16);
    step();
  endtask

  task automatic test_wrap16();
    rst16_n = 1'b0;
    step();
    step();
    rst16_n      = 1'b1;
    req_ready16  = 1'b1;
    inst_ready16 = 1'b1;
    acc16        = 1'b0;
    prev_addr16  = 16'h0;
    // k0: redirect to 0xFFFE (low bits ignored)
    wrap_drive(1'b1);
    tests++; if (req_valid16 !== 1'b0) begin fails++; $display("FAIL wrap_k0_valid: got %b want 0", req_valid16); end
`ifdef CPU_FETCH_PERF_EN
    tests++; if (perf16 !== 32'd0) begin fails++; $display("FAIL wrap_perf_k0: got %0d want 0", perf16); end
`endif
    wrap_advance();
    // k1
    wrap_drive(1'b0);
    tests++; if (req_valid16 !== 1'b1) begin fails++; $display("FAIL wrap_k1_valid: got %b want 1", req_valid16); end
    tests++; if (req_addr16 !== 16'hFFFC) begin fails++; $display("FAIL wrap_k1_addr: got %h want fffc", req_addr16); end
    wrap_advance();
    // k2
    wrap_drive(1'b0);
    tests++; if (req_addr16 !== 16'h0000) begin fails++; $display("FAIL wrap_k2_addr: got %h want 0000", req_addr16); end
    tests++; if (inst_valid16 !== 1'b0) begin fails++; $display("FAIL wrap_k2_inst_valid: got %b want 0", inst_valid16); end
    wrap_advance();
    // k3
    wrap_drive(1'b0);
    tests++; if (inst_valid16 !== 1'b1) begin fails++; $display("FAIL wrap_k3_inst_valid: got %b want 1", inst_valid16); end
    tests++; if (inst_pc16 !== 16'hFFFC) begin fails++; $display("FAIL wrap_k3_inst_pc: got %h want fffc", inst_pc16); end
    tests++; if (inst16 !== 32'hB000_FFFC) begin fails++; $display("FAIL wrap_k3_inst: got %h want b000fffc", inst16); end
`ifdef CPU_FETCH_PERF_EN
    tests++; if (perf16 !== 32'd2) begin fails++; $display("FAIL wrap_perf_k3: got %0d want 2", perf16); end
`endif
    wrap_advance();
    // k4
    wrap_drive(1'b0);
    tests++; if (inst_pc16 !== 16'h0000) begin fails++; $display("FAIL wrap_k4_inst_pc: got %h want 0000", inst_pc16); end
    tests++; if (inst16 !== 32'hB000_0000) begin fails++; $display("FAIL wrap_k4_inst: got %h want b0000000", inst16); end
    tests++; if (req_addr16 !== 16'h0008) begin fails++; $display("FAIL wrap_k4_addr: got %h want 0008", req_addr16); end
    wrap_advance();
    wrap_drive(1'b0);
    wrap_advance();
    // k6: stream continuous, no further bubbles
    wrap_drive(1'b0);
    tests++; if (inst_pc16 !== 16'h0008) begin fails++; $display("FAIL wrap_k6_inst_pc: got %h want 0008", inst_pc16); end
`ifdef CPU_FETCH_PERF_EN
    tests++; if (perf16 !== 32'd2) begin fails++; $display("FAIL wrap_perf_k6: got %0d want 2", perf16); end
`endif
    wrap_advance();
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b1;
    rst16_n        = 1'b0;
    redirect16     = 1'b0;
    redirect_pc16  = 16'h0;
    req_ready16    = 1'b0;
    rsp_valid16    = 1'b0;
    rsp_data16     = 32'h0;
    inst_ready16   = 1'b0;
    acc16          = 1'b0;
    prev_addr16    = 16'h0;
    @(negedge clk);

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_flush_full();
    test_back_to_back();
    test_stall_and_reset();
    test_wrap16();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, instruction-address width (16..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, prefetch-buffer entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (bits [1:0] zero).
REQ-004 SHALL have one clock and one synchronous, active-low reset.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port redirect_valid  input  1  flush buffer and restart fetch at redirect_pc.
REQ-008 SHALL have port redirect_pc  input  ADDR_W  new fetch address; bits [1:0] ignored (treated as 0).
REQ-009 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-010 SHALL have port imem_req_addr  output  ADDR_W  word-aligned fetch address.
REQ-011 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-012 SHALL have port imem_rsp_valid  input  1  instruction word returned; responses in request order.
REQ-013 SHALL have port imem_rsp_data  input  32  returned instruction.
REQ-014 SHALL have port inst_valid  output  1  buffered instruction available.
REQ-015 SHALL have port inst  output  32  head-of-buffer instruction.
REQ-016 SHALL have port inst_pc  output  ADDR_W  address of inst.
REQ-017 SHALL have port inst_ready  input  1  consumer takes inst.

Function
REQ-018 SHALL keep fetch_pc; request handshake (valid&ready) SHALL advance fetch_pc by 4, wrapping modulo 2^ADDR_W.
REQ-019 SHALL drive imem_req_addr = fetch_pc; addr SHALL stay stable while valid && !ready.
REQ-020 SHALL assert imem_req_valid iff !redirect_valid && (fifo_count + inflight) < FIFO_DEPTH; once asserted SHALL hold until accepted unless redirect_valid withdraws it.
REQ-021 SHALL support up to FIFO_DEPTH requests in flight; a response may arrive no earlier than the cycle after its acceptance.
REQ-022 SHALL write each kept response, with its address, into the FIFO; inst/inst_pc SHALL appear with inst_valid the cycle after imem_rsp_valid (one-cycle latency, registered outputs).
REQ-023 SHALL pop the head on inst_valid && inst_ready; simultaneous push and pop SHALL keep count unchanged and order intact.
REQ-024 FIFO overflow SHALL be impossible by the credit rule (REQ-020); no response SHALL be dropped except per REQ-026.
REQ-025 On redirect_valid: next edge SHALL clear FIFO, set fetch_pc = {redirect_pc[ADDR_W-1:2],2'b00}, set drop_cnt = inflight (including any request accepted or response received in that cycle); inst_valid SHALL be forced low combinationally in the redirect cycle.
REQ-026 While drop_cnt > 0, each imem_rsp_valid SHALL be discarded and decrement drop_cnt; new requests SHALL be issued meanwhile within credit.
REQ-027 Back-to-back redirects SHALL each take effect; last one wins; drop_cnt SHALL accumulate correctly.

Reset
REQ-028 While rst_n = 0 at an edge: fetch_pc = RESET_PC, FIFO empty, inflight = 0, drop_cnt = 0; imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0.
REQ-029 imem_rsp_valid and redirect_valid SHALL be ignored while rst_n = 0; memory shares rst_n, so no pre-reset response returns afterward.
REQ-030 First cycle with rst_n = 1 SHALL present imem_req_valid = 1, imem_req_addr = RESET_PC.

Configuration
REQ-031 With macro CPU_FETCH_PERF_EN defined, SHALL add output perf_bubble_cnt (32 bits, wraps), incrementing each non-reset cycle with inst_valid = 0 && !redirect_valid, cleared by reset.
REQ-032 Without CPU_FETCH_PERF_EN, the port and counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-033 Reset release, req_ready=1, 1-cycle memory, inst_ready=1 -> requests at 0x0,0x4,0x8...; inst_pc 0x0 appears 2 cycles after first request, then one per cycle.
REQ-034 inst_ready=0, req_ready=1 -> exactly 4 requests (DEPTH=4), then req_valid low; raise inst_ready -> fetch resumes, order 0x0..0xC preserved.
REQ-035 2 requests in flight, redirect_pc=0x103 -> both old responses discarded, next request addr 0x100, first inst_pc 0x100.
REQ-036 req_ready=0 for 5 cycles -> addr held at 0x0 with req_valid high; rst_n=0 mid-stream -> all outputs 0, restart at RESET_PC.
REQ-037 ADDR_W=16, redirect to 0xFFFC -> fetch 0xFFFC then wraps to 0x0000; with CPU_FETCH_PERF_EN, perf_bubble_cnt counts the bubble cycles exactly.
